// File: rtl/hpc_pulse_issuer.sv
// hpc_pulse_issuer
//   Source-domain initiator for a handshake pulse synchronizer. Event strobes
//   are counted into a pending queue. Queued events are issued one at a time as
//   single-cycle pulses. A new pulse is issued only while the synchronizer's
//   busy is low, so no event is lost while a transfer is in flight.
//
// Parameters
//   CNT_W   width of the pending-event counter (saturates at 2^CNT_W-1)
//   TO_CYC  consecutive busy-high cycles in WAIT_DONE that raise timeout (4..65535)
//
// Ports
//   src_clkA  in   source-domain clock, rising edge
//   rstA      in   asynchronous active-low reset
//   ev_in     in   event strobe, one event per high cycle
//   hs_busy   in   synchronizer busy, same clock domain
//   err_clr   in   clears the overflow and timeout sticky flags
//   hs_pulse  out  registered single-cycle pulse to the synchronizer
//   pending   out  events queued and not yet issued
//   idle      out  FSM in IDLE with nothing pending
//   overflow  out  sticky, an event was dropped on a full queue
//   timeout   out  sticky, busy stayed high for TO_CYC cycles
module hpc_pulse_issuer #(
  parameter int CNT_W  = 4,
  parameter int TO_CYC = 64
) (
  input  logic             src_clkA,
  input  logic             rstA,
  input  logic             ev_in,
  input  logic             hs_busy,
  input  logic             err_clr,
  output logic             hs_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             idle,
  output logic             overflow,
  output logic             timeout
);

  localparam int TCNT_W = $clog2(TO_CYC + 1);
  localparam logic [TCNT_W-1:0] TO_LIM = TCNT_W'(TO_CYC);
  localparam logic [CNT_W-1:0]  PMAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_GUARD     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               to_q, to_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [TCNT_W-1:0]  tcnt_inc;
  logic               issue;
  logic               ovf_set;
  logic               to_set;

  assign tcnt_inc = tcnt_q + 1'b1;

  // FSM next state, pulse generation and timeout counting
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    tcnt_d  = tcnt_q;
    issue   = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) && !hs_busy) begin
          issue   = 1'b1;
          pulse_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        // The synchronizer raises busy one cycle after it samples the pulse,
        // so busy is not trusted here; start a fresh timeout window instead.
        tcnt_d  = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!hs_busy) begin
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TO_LIM) begin
            // Give up waiting; IDLE still refuses to issue while busy is high.
            to_set  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending counter: simultaneous accept and issue cancel out, even when full
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (ev_in && !issue) begin
      if (pend_q == PMAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!ev_in && issue) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Sticky flags: a same-cycle set wins over err_clr
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    to_d  = to_set  | (to_q  & ~err_clr);
  end

  always_ff @(posedge src_clkA or negedge rstA) begin
    if (!rstA) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign hs_pulse = pulse_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign timeout  = to_q;
  assign idle     = (state_q == ST_IDLE) && (pend_q == '0);

endmodule

// File: tb/tb_hpc_pulse_issuer.sv
module tb_hpc_pulse_issuer;

  localparam int CNT_W    = 4;
  localparam int TO_CYC   = 8;
  localparam int BUSY_LEN = 6;

  logic             clk = 1'b0;
  logic             rstA;
  logic             ev_in;
  logic             err_clr;
  logic             hs_busy;
  logic             hs_pulse;
  logic [CNT_W-1:0] pending;
  logic             idle;
  logic             overflow;
  logic             timeout;

  // synchronizer busy model: programmable hold plus a fixed-length busy per pulse
  logic busy_hold;
  int   busy_left;
  logic busy_at_edge;
  logic prev_pulse;

  int total;
  int bad;
  int pulses_seen;
  int tok_in;
  int tok_out;
  int exp_q[$];

  assign hs_busy = busy_hold | (busy_left != 0);

  hpc_pulse_issuer #(.CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
    .src_clkA (clk),
    .rstA     (rstA),
    .ev_in    (ev_in),
    .hs_busy  (hs_busy),
    .err_clr  (err_clr),
    .hs_pulse (hs_pulse),
    .pending  (pending),
    .idle     (idle),
    .overflow (overflow),
    .timeout  (timeout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) busy_at_edge = hs_busy;

  // pulse monitor and scoreboard consumer
  always @(negedge clk) begin
    if (rstA) begin
      if (hs_pulse) begin
        pulses_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_pulse: got unexpected pulse, expected no pending event");
        end else begin
          int t;
          t = exp_q.pop_front();
          if (t !== tok_out) begin
            bad++;
            $display("FAIL sb_order: got token %0d, expected %0d", t, tok_out);
          end
          tok_out++;
        end
        total++;
        if (busy_at_edge !== 1'b0) begin
          bad++;
          $display("FAIL pulse_vs_busy: busy=%b at issuing edge, expected 0", busy_at_edge);
        end
        total++;
        if (prev_pulse) begin
          bad++;
          $display("FAIL pulse_width: pulse high 2 cycles, expected 1");
        end
      end
      prev_pulse = hs_pulse;
      if (busy_left > 0) busy_left--;
      if (hs_pulse) busy_left = BUSY_LEN;
    end else begin
      prev_pulse = 1'b0;
      busy_left  = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_ev();
    exp_q.push_back(tok_in);
    tok_in++;
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (idle && !hs_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rstA = 1'b0; ev_in = 1'b0; err_clr = 1'b0; busy_hold = 1'b0;
    repeat (3) tick();
    total++;
    if ({hs_pulse, pending, idle, overflow, timeout} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals: got p=%b pend=%0d idle=%b ovf=%b to=%b, expected 0 0 1 0 0",
               hs_pulse, pending, idle, overflow, timeout);
    end
    rstA = 1'b1;
    repeat (2) tick();
    total++;
    if (hs_pulse !== 1'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got p=%b idle=%b, expected 0 1", hs_pulse, idle);
    end
  endtask

  task automatic test_single();
    int p0;
    bit ok;
    p0 = pulses_seen;
    ev_in = 1'b1; push_ev();
    tick();
    ev_in = 1'b0;
    total++;
    if (pending !== 4'd1 || hs_pulse !== 1'b0 || idle !== 1'b0) begin
      bad++;
      $display("FAIL single_e0: got pend=%0d p=%b idle=%b, expected 1 0 0", pending, hs_pulse, idle);
    end
    tick();
    total++;
    if (hs_pulse !== 1'b1 || pending !== 4'd0) begin
      bad++;
      $display("FAIL single_e1: got p=%b pend=%0d, expected 1 0", hs_pulse, pending);
    end
    tick();
    total++;
    if (hs_pulse !== 1'b0) begin
      bad++;
      $display("FAIL single_e2: got p=%b, expected 0", hs_pulse);
    end
    wait_drain(40, ok);
    total++;
    if (!ok || pulses_seen - p0 !== 1) begin
      bad++;
      $display("FAIL single_done: got drained=%b pulses=%0d, expected 1 1", ok, pulses_seen - p0);
    end
  endtask

  task automatic test_burst();
    int p0;
    int peak;
    bit ok;
    p0 = pulses_seen;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      ev_in = 1'b1; push_ev();
      tick();
      if (int'(pending) > peak) peak = int'(pending);
    end
    ev_in = 1'b0;
    wait_drain(200, ok);
    total++;
    if (!ok || pulses_seen - p0 !== 5) begin
      bad++;
      $display("FAIL burst_pulses: got drained=%b pulses=%0d, expected 1 5", ok, pulses_seen - p0);
    end
    total++;
    if (peak < 4 || peak > 5) begin
      bad++;
      $display("FAIL burst_peak: got %0d, expected 4 or 5", peak);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL burst_ovf: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int p0;
    bit ok;
    p0 = pulses_seen;
    busy_hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ev_in = 1'b1;
      if (i < 15) push_ev();
      tick();
    end
    ev_in = 1'b0;
    total++;
    if (pending !== 4'd15 || overflow !== 1'b1 || pulses_seen != p0) begin
      bad++;
      $display("FAIL ovf_sat: got pend=%0d ovf=%b pulses=%0d, expected 15 1 0",
               pending, overflow, pulses_seen - p0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: got %b, expected 0", overflow);
    end
    busy_hold = 1'b0;
    wait_drain(400, ok);
    total++;
    if (!ok || pulses_seen - p0 !== 15) begin
      bad++;
      $display("FAIL ovf_drain: got drained=%b pulses=%0d, expected 1 15", ok, pulses_seen - p0);
    end
  endtask

  task automatic test_full_simul();
    int p0;
    bit ok;
    p0 = pulses_seen;
    busy_hold = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ev_in = 1'b1; push_ev();
      tick();
    end
    ev_in = 1'b0;
    tick();
    total++;
    if (pending !== 4'd15 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_fill: got pend=%0d ovf=%b, expected 15 0", pending, overflow);
    end
    busy_hold = 1'b0;
    ev_in = 1'b1; push_ev();
    tick();
    ev_in = 1'b0;
    total++;
    if (pending !== 4'd15 || hs_pulse !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_simul: got pend=%0d p=%b ovf=%b, expected 15 1 0", pending, hs_pulse, overflow);
    end
    wait_drain(500, ok);
    total++;
    if (!ok || pulses_seen - p0 !== 16) begin
      bad++;
      $display("FAIL full_drain: got drained=%b pulses=%0d, expected 1 16", ok, pulses_seen - p0);
    end
  endtask

  task automatic test_timeout();
    int p0;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      busy_hold = 1'b0;
      ev_in = 1'b1; push_ev();
      tick();
      ev_in = 1'b0;
      tick();
      total++;
      if (hs_pulse !== 1'b1) begin
        bad++;
        $display("FAIL to_pulse%0d: got %b, expected 1", it, hs_pulse);
      end
      busy_hold = 1'b1;
      repeat (9) tick();
      total++;
      if (timeout !== 1'b0) begin
        bad++;
        $display("FAIL to_early%0d: got %b, expected 0", it, timeout);
      end
      if (it == 1) err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++;
      if (timeout !== 1'b1 || idle !== 1'b1) begin
        bad++;
        $display("FAIL to_set%0d: got to=%b idle=%b, expected 1 1", it, timeout, idle);
      end
      if (it == 0) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (timeout !== 1'b0) begin
          bad++;
          $display("FAIL to_clr: got %b, expected 0", timeout);
        end
      end
    end
    // busy still stuck: a new event queues but must not issue
    p0 = pulses_seen;
    ev_in = 1'b1; push_ev();
    tick();
    ev_in = 1'b0;
    repeat (6) tick();
    total++;
    if (pending !== 4'd1 || pulses_seen != p0) begin
      bad++;
      $display("FAIL to_hold: got pend=%0d pulses=%0d, expected 1 0", pending, pulses_seen - p0);
    end
    busy_hold = 1'b0;
    wait_drain(40, ok);
    total++;
    if (!ok || pulses_seen - p0 !== 1) begin
      bad++;
      $display("FAIL to_release: got drained=%b pulses=%0d, expected 1 1", ok, pulses_seen - p0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p0;
    busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_in = 1'b1; push_ev();
      tick();
    end
    ev_in = 1'b0;
    tick();
    busy_hold = 1'b0;
    tick();
    total++;
    if (hs_pulse !== 1'b1 || pending !== 4'd3) begin
      bad++;
      $display("FAIL rst_mid_issue: got p=%b pend=%0d, expected 1 3", hs_pulse, pending);
    end
    tick();
    total++;
    if (pending !== 4'd3 || hs_pulse !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_guard: got pend=%0d p=%b, expected 3 0", pending, hs_pulse);
    end
    rstA = 1'b0;
    #1;
    total++;
    if ({hs_pulse, pending, idle, overflow, timeout} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_async: got p=%b pend=%0d idle=%b ovf=%b to=%b, expected 0 0 1 0 0",
               hs_pulse, pending, idle, overflow, timeout);
    end
    exp_q.delete();
    tok_out = tok_in;
    tick();
    tick();
    rstA = 1'b1;
    p0 = pulses_seen;
    repeat (20) tick();
    total++;
    if (pulses_seen != p0 || pending !== 4'd0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_after: got pulses=%0d pend=%0d idle=%b, expected 0 0 1",
               pulses_seen - p0, pending, idle);
    end
  endtask

  initial begin
    total = 0; bad = 0; pulses_seen = 0; tok_in = 0; tok_out = 0;
    busy_left = 0; busy_hold = 1'b0; prev_pulse = 1'b0; busy_at_edge = 1'b0;
    rstA = 1'b0; ev_in = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_simul();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/hpc_pulse_issuer.md
Name: hpc_pulse_issuer

Overview:
- Source-domain initiator that drives the handshake pulse synchronizer's input pulse and watches its busy output.
- Accepts single-cycle event strobes at any rate and queues them as a pending count.
- Issues them one at a time as single-cycle pulses, each only after the synchronizer's busy has dropped, so no event is lost while a transfer is in flight.
- Single clock: the synchronizer's source clock.

Parameters:
- CNT_W, 4, width of the pending-event counter; maximum pending count PMAX = 2^CNT_W - 1.
- TO_CYC, 64, number of consecutive busy-high cycles in WAIT_DONE that triggers the timeout flag; legal range 4..65535.

Ports:
- src_clkA  input  1  source-domain clock; all logic on the rising edge.
- rstA  input  1  asynchronous active-low reset.
- ev_in  input  1  event strobe; each high cycle is one event.
- hs_busy  input  1  busy from the pulse synchronizer, same clock domain.
- err_clr  input  1  clears the overflow and timeout sticky flags.
- hs_pulse  output  1  registered single-cycle pulse to the synchronizer input.
- pending  output  CNT_W  events queued and not yet issued.
- idle  output  1  high when state is IDLE and pending == 0.
- overflow  output  1  sticky; an event was dropped.
- timeout  output  1  sticky; busy was stuck high for TO_CYC cycles.

Behaviour:
- Reset (async assert, sync release): state=IDLE, hs_pulse=0, pending=0, overflow=0, timeout=0, timeout counter=0, idle=1. Reset mid-transfer discards all pending events. No pulse is emitted after release until a new ev_in arrives.
- FSM states: IDLE, ISSUE, GUARD, WAIT_DONE.
  - IDLE: if pending != 0 and hs_busy == 0 at the edge, then hs_pulse<=1, pending decrements, next state ISSUE. Otherwise stay in IDLE.
  - ISSUE: hs_pulse<=0, next state GUARD. hs_pulse is therefore high for exactly one cycle.
  - GUARD: one cycle; hs_busy is ignored because the synchronizer's busy rises one cycle after it samples the pulse. Next state WAIT_DONE; the timeout counter is cleared.
  - WAIT_DONE: if hs_busy == 0, next state IDLE. Otherwise the timeout counter increments. When it reaches TO_CYC: timeout<=1, next state IDLE (IDLE still gates issuing on hs_busy == 0).
- Latency: ev_in high at edge E0 with an empty queue and hs_busy low gives pending=1 after E0, and hs_pulse high between E1 and E2.
- Minimum issue spacing is 4 cycles (IDLE, ISSUE, GUARD, WAIT_DONE), extended by the synchronizer's busy duration.
- Pending counter update, evaluated each edge:
  - inc = ev_in accepted; dec = IDLE issuing.
  - inc and dec together: pending unchanged. This applies even when pending == PMAX, and the event is not dropped.
  - inc only with pending == PMAX: event dropped, pending stays PMAX, overflow<=1.
  - No wrap-around in either direction. dec never occurs with pending == 0.
- Sticky flags:
  - err_clr clears overflow and timeout on the next edge.
  - A same-cycle set condition takes priority over err_clr (flag stays 1).
- idle is combinational from registered state and pending only.
- hs_busy high while in IDLE (e.g. a transfer still completing after reset release): no issue; events continue to queue.

Test Plan:
- Single event: pulse ev_in 1 cycle, hs_busy modelled high 6 cycles starting 1 cycle after hs_pulse -> hs_pulse high exactly 1 cycle, 2 edges after ev_in; pending 1 -> 0; idle returns to 1 after busy falls.
- Burst: ev_in high 5 consecutive cycles, busy 6 cycles per transfer -> pending peaks at 4 or 5. Exactly 5 hs_pulses, each 1 cycle wide, none while hs_busy=1; overflow stays 0.
- Overflow: CNT_W=4, hold hs_busy=1, apply 17 ev_in cycles -> pending saturates at 15, overflow=1, no hs_pulse. err_clr -> overflow=0. Release busy -> exactly 15 pulses.
- Simultaneous inc/dec at full: pending=15, IDLE, busy low, ev_in=1 at the issuing edge -> pending stays 15, hs_pulse=1, overflow stays 0.
- Timeout: TO_CYC=8, busy stuck high after a pulse -> timeout=1 after 8 WAIT_DONE cycles; FSM in IDLE; no further pulse until busy low; err_clr same cycle as a new timeout leaves it set.
- Reset mid-operation: assert rstA during GUARD with pending=3 -> all outputs go to reset values immediately; no pulse after release without new ev_in.
